prf_free_list: RTL
==================

// Module: prf_free_list
// PURPOSE
//  Circular free list of physical register ids for the rename stage, upstream of issue.
//  - Hands out up to MACHINE_WIDTH new destination pregs per cycle.
//  - Takes back the previous mapping of each committed destination.
//  - On flush, reclaims every speculative allocation in one cycle by restoring the
//    read pointer to its committed copy. No checkpoints are used.
// PARAMETERS
//  MACHINE_WIDTH  2   lanes allocated / released per cycle
//  PRF_NUM        64  physical registers; preg id width PW = $clog2(PRF_NUM)
//  AREG_NUM       32  architectural regs; p0..p31 are mapped at reset, never in list at reset
//  FL_DEPTH       32  = PRF_NUM-AREG_NUM, power of two; pointers are $clog2(FL_DEPTH)+1 bits
// PORTS
//  clk            in   1        single clock, rising edge
//  reset          in   1        synchronous, active-high
//  flush          in   1        mispredict/exception squash from commit
//  alloc_req      in   W        lane i needs a new dst (renamer clears it for $zero / no-dst)
//  alloc_ok       out  1        enough free ids for all set alloc_req lanes
//  alloc_id       out  W*PW     id granted per lane, valid where alloc_req[i]
//  commit_valid   in   W        committing instr in lane i had an allocated dst
//  commit_old_id  in   W*PW     previous preg of that dst, returned to the list
//  free_count     out  PW       number of ids currently allocatable
// BEHAVIOUR
//  - State: entries[FL_DEPTH], head (spec read), cm_head (committed read), tail (write).
//    All pointers carry a wrap bit. free_count = tail - head.
//  - Reset: entries[i]=AREG_NUM+i, head=cm_head=0, tail=FL_DEPTH (full).
//    After reset: free_count=32, alloc_ok=1, alloc_id={33,32} (lane1,lane0).
//  - Allocation:
//    - Compacted: the k-th set bit of alloc_req, counting from lane 0, gets entries[head+k].
//      Unrequested lanes' alloc_id is don't-care.
//    - alloc_ok = (free_count >= popcount(alloc_req)). Combinational, zero latency.
//    - Fire = alloc_ok & |alloc_req & ~flush. Then head += popcount(alloc_req).
//    - All-or-nothing: partial grants are never made. When not firing, head holds and the
//      same ids are re-offered.
//  - Release:
//    - Compacted: the k-th set commit_valid lane writes commit_old_id to entries[tail+k].
//    - tail += n_c and cm_head += n_c, where n_c = popcount(commit_valid).
//    - Released ids become allocatable next cycle; no same-cycle bypass.
//  - Flush: head <= cm_head + n_c. Same-cycle commit still completes; alloc is ignored.
//    free_count the next cycle = tail_next - head_next.
//  - Simultaneous alloc and release: both apply. free_count changes by n_c - n_a.
//  - Wrap-around: index with the low bits; the wrap bit distinguishes full from empty.
//  - Never full-overflow: a release with free_count + n_c > FL_DEPTH is an illegal protocol
//    error and is asserted in simulation. The same applies to cm_head overtaking head.
//  - reset overrides flush, alloc and commit in the same cycle.
// STRUCTURE
//  - renaming_pkg: preg_t (logic[PW-1:0]), PRF_NUM, AREG_NUM, FL_DEPTH, fl_ptr_t.
//  - One sub-module: lane_compact. For a W-bit mask it produces each lane's prefix offset
//    and the total popcount. It is used for both alloc and release.
//  - Entries are a flop array, not BRAM, because reset init and W read ports are needed.
// TESTING
//  1 reset; alloc_req=2'b11 -> alloc_ok=1, ids {33,32}; next cycle free_count=30, ids {35,34}.
//  2 fresh reset, alloc_req=2'b10 -> lane1 id=32; next cycle alloc_req=2'b11 -> {34,33}.
//  3 16 cycles alloc_req=2'b11 -> free_count=0; alloc_req=2'b01 -> alloc_ok=0, head unchanged.
//    Then commit_valid=2'b11, old ids {7,5} -> next cycle free_count=2, alloc gives {7,5}.
//  4 3 allocs (ids 32,33,34), no commit, then flush -> free_count=32; next alloc -> {33,32}.
//  5 flush with commit_valid=2'b01 old_id=3 in same cycle, alloc_req=2'b11 -> no alloc fires;
//    cm_head advances by 1; free_count = previous committed value (at that point reflects the
//    one committed allocation).
//  6 random 10k cycles vs scoreboard model, including wrap: no id is duplicated among live
//    mappings plus free list, and the union is always exactly PRF_NUM ids.

Source files
------------

// File: rtl/renaming_pkg.sv
// Shared rename-stage types and sizes for the physical register free list.
// Exports preg_t, fl_ptr_t and the PRF / free-list geometry.
package renaming_pkg;
  localparam int MACHINE_WIDTH = 2;
  localparam int PRF_NUM = 64;
  localparam int AREG_NUM = 32;
  localparam int FL_DEPTH = PRF_NUM - AREG_NUM;
  localparam int PW = $clog2(PRF_NUM);
  localparam int FL_IW = $clog2(FL_DEPTH);
  localparam int FL_PW = FL_IW + 1;

  typedef logic [PW-1:0] preg_t;
  typedef logic [FL_PW-1:0] fl_ptr_t;
endpackage

// File: rtl/prf_free_list_lane_compact.sv
// Lane compaction helper: per-lane prefix offset and total popcount of a mask.
// Ports: i_mask (W lanes) -> o_offs (W x CW offsets, lane 0 low), o_count.
module lane_compact #(
  parameter int W = 2,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]    i_mask,
  output logic [W*CW-1:0] o_offs,
  output logic [CW-1:0]   o_count
);

  always_comb begin
    logic [CW-1:0] v_acc;
    v_acc = '0;
    o_offs = '0;
    for (int i = 0; i < W; i++) begin
      o_offs[i*CW +: CW] = v_acc;
      v_acc = v_acc + CW'(i_mask[i]);
    end
    o_count = v_acc;
  end

endmodule

// File: rtl/prf_free_list.sv
// Circular free list of physical register ids with committed-head flush recovery.
// Ports: clk, reset, flush; alloc_req/alloc_ok/alloc_id; commit_valid/commit_old_id; free_count.
module prf_free_list
  import renaming_pkg::*;
#(
  parameter int MACHINE_WIDTH = renaming_pkg::MACHINE_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [MACHINE_WIDTH-1:0]    alloc_req,
  output logic                        alloc_ok,
  output logic [MACHINE_WIDTH*PW-1:0] alloc_id,
  input  logic [MACHINE_WIDTH-1:0]    commit_valid,
  input  logic [MACHINE_WIDTH*PW-1:0] commit_old_id,
  output logic [PW-1:0]               free_count
);

  localparam int W = MACHINE_WIDTH;
  localparam int CW = $clog2(W + 1);

  preg_t   r_entries [FL_DEPTH];
  fl_ptr_t r_head;
  fl_ptr_t r_cm_head;
  fl_ptr_t r_tail;

  logic [W*CW-1:0] w_a_offs;
  logic [W*CW-1:0] w_c_offs;
  logic [CW-1:0]   w_n_a;
  logic [CW-1:0]   w_n_c;
  fl_ptr_t         w_used;
  fl_ptr_t         w_rptr [W];
  fl_ptr_t         w_wptr [W];
  fl_ptr_t         w_head_nxt;
  fl_ptr_t         w_cm_nxt;
  fl_ptr_t         w_tail_nxt;
  logic            w_fire;

  lane_compact #(.W(W), .CW(CW)) u_alloc_cmp (
    .i_mask  (alloc_req),
    .o_offs  (w_a_offs),
    .o_count (w_n_a)
  );

  lane_compact #(.W(W), .CW(CW)) u_rel_cmp (
    .i_mask  (commit_valid),
    .o_offs  (w_c_offs),
    .o_count (w_n_c)
  );

  // The wrap bit makes tail - head range 0..FL_DEPTH.
  assign w_used = r_tail - r_head;
  assign free_count = PW'(w_used);
  assign alloc_ok = (w_used >= fl_ptr_t'(w_n_a));
  assign w_fire = alloc_ok & (|alloc_req) & ~flush;

  always_comb begin
    for (int i = 0; i < W; i++) begin
      w_rptr[i] = r_head + fl_ptr_t'(w_a_offs[i*CW +: CW]);
      w_wptr[i] = r_tail + fl_ptr_t'(w_c_offs[i*CW +: CW]);
    end
  end

  always_comb begin
    alloc_id = '0;
    for (int i = 0; i < W; i++) begin
      alloc_id[i*PW +: PW] = r_entries[w_rptr[i][FL_IW-1:0]];
    end
  end

  // Flush drops every speculative grant: the read side falls back to
  // the committed head, including commits retiring this same cycle.
  assign w_cm_nxt = r_cm_head + fl_ptr_t'(w_n_c);
  assign w_tail_nxt = r_tail + fl_ptr_t'(w_n_c);
  assign w_head_nxt = flush  ? w_cm_nxt :
                      w_fire ? r_head + fl_ptr_t'(w_n_a) :
                               r_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        r_entries[i] <= preg_t'(AREG_NUM + i);
      end
      r_head <= '0;
      r_cm_head <= '0;
      r_tail <= fl_ptr_t'(FL_DEPTH);
    end else begin
      for (int i = 0; i < W; i++) begin
        if (commit_valid[i]) begin
          r_entries[w_wptr[i][FL_IW-1:0]] <= commit_old_id[i*PW +: PW];
        end
      end
      r_head <= w_head_nxt;
      r_cm_head <= w_cm_nxt;
      r_tail <= w_tail_nxt;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (int'(w_used) + int'(w_n_c) <= FL_DEPTH));

  a_cm_behind_head: assert property (@(posedge clk) disable iff (reset)
    (int'(fl_ptr_t'(r_head - r_cm_head)) >= int'(w_n_c)));

endmodule
